// File: rtl/trigger_capture.sv
// Multi-channel trigger and capture engine: circular sample buffer, level-crossing trigger
// with hysteresis, pre-trigger depth, normal/auto mode and a trigger-aligned read port.
module trigger_capture #(
    parameter int DATA_W       = 12,
    parameter int CHANNELS     = 2,
    parameter int DEPTH        = 256,
    parameter int PRE_TRIG     = 64,
    parameter int AUTO_TIMEOUT = 4096,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    // Samples have no back-pressure: a sample set is consumed on every cycle sample_valid is 1.
    input  logic                       sample_valid,
    input  logic [CHANNELS*DATA_W-1:0] sample_data,
    input  logic                       arm,
    input  logic [CH_W-1:0]            trig_channel,
    input  logic [DATA_W-1:0]          trig_level,
    input  logic [DATA_W-1:0]          trig_hyst,
    input  logic [1:0]                 trig_edge,
    input  logic                       auto_mode,
    input  logic [AW-1:0]              rd_addr,
    output logic [CHANNELS*DATA_W-1:0] rd_data,
    output logic                       busy,
    output logic                       triggered,
    output logic                       auto_fired,
    output logic                       capture_done
);
    localparam int CNT_MAX = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int POST_N  = DEPTH - PRE_TRIG - 1;
    localparam logic [CNT_W-1:0] PRE_C  = CNT_W'(PRE_TRIG);
    localparam logic [CNT_W-1:0] AUTO_C = CNT_W'(AUTO_TIMEOUT);
    localparam logic [CNT_W-1:0] POST_C = CNT_W'(POST_N);
    localparam logic [AW-1:0]    PRE_A  = AW'(PRE_TRIG);

    typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, DONE} state_t;

    state_t                      state, state_nx;
    logic [CNT_W-1:0]            cnt, cnt_nx, cnt_inc;
    logic [AW-1:0]               wr_ptr, trig_ptr, trig_ptr_nx, rd_ptr;
    logic [DATA_W-1:0]           prev, cur, lo, hi;
    logic [DATA_W:0]             hi_sum;
    logic                        have_prev, rise_ok, fall_ok;
    logic                        is_rise, is_fall, hit, track, wr_en;
    logic                        triggered_nx, auto_fired_nx, capture_done_nx;
    int                          ch_idx;
    logic [CHANNELS*DATA_W-1:0]  mem [DEPTH];

    // Trigger channel value and saturated hysteresis thresholds.
    always_comb begin
        ch_idx = (int'(trig_channel) < CHANNELS) ? int'(trig_channel) : 0;
        cur    = sample_data[ch_idx*DATA_W +: DATA_W];
        lo     = (trig_level > trig_hyst) ? trig_level - trig_hyst : '0;
        hi_sum = {1'b0, trig_level} + {1'b0, trig_hyst};
        hi     = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
    end

    assign is_rise = have_prev && (prev < trig_level) && (cur >= trig_level)
                     && ((trig_hyst == '0) || rise_ok);
    assign is_fall = have_prev && (prev > trig_level) && (cur <= trig_level)
                     && ((trig_hyst == '0) || fall_ok);

    always_comb begin
        case (trig_edge)
            2'b01:   hit = is_fall;
            2'b10:   hit = is_rise || is_fall;
            default: hit = is_rise;
        endcase
    end

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        trig_ptr_nx     = trig_ptr;
        triggered_nx    = triggered;
        auto_fired_nx   = auto_fired;
        capture_done_nx = capture_done;
        wr_en           = 1'b0;
        track           = 1'b0;
        if (arm) begin
            state_nx        = (PRE_TRIG == 0) ? WAIT_TRIG : PRE_FILL;
            cnt_nx          = '0;
            triggered_nx    = 1'b0;
            auto_fired_nx   = 1'b0;
            capture_done_nx = 1'b0;
        end else if (sample_valid) begin
            case (state)
                PRE_FILL: begin
                    wr_en = 1'b1;
                    track = 1'b1;
                    if (cnt_inc == PRE_C) begin
                        state_nx = WAIT_TRIG;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                WAIT_TRIG: begin
                    wr_en = 1'b1;
                    track = 1'b1;
                    // Count saturates so a long normal-mode wait never wraps.
                    if (cnt != AUTO_C) cnt_nx = cnt_inc;
                    if (hit || (auto_mode && (cnt_inc >= AUTO_C))) begin
                        trig_ptr_nx   = wr_ptr;
                        triggered_nx  = 1'b1;
                        auto_fired_nx = !hit;
                        cnt_nx        = '0;
                        if (POST_N == 0) begin
                            state_nx        = DONE;
                            capture_done_nx = 1'b1;
                        end else begin
                            state_nx = POST_FILL;
                        end
                    end
                end
                POST_FILL: begin
                    wr_en = 1'b1;
                    if (cnt_inc == POST_C) begin
                        state_nx        = DONE;
                        capture_done_nx = 1'b1;
                        cnt_nx          = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wr_ptr       <= '0;
            trig_ptr     <= '0;
            prev         <= '0;
            have_prev    <= 1'b0;
            rise_ok      <= 1'b0;
            fall_ok      <= 1'b0;
            triggered    <= 1'b0;
            auto_fired   <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            trig_ptr     <= trig_ptr_nx;
            triggered    <= triggered_nx;
            auto_fired   <= auto_fired_nx;
            capture_done <= capture_done_nx;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (arm) begin
                have_prev <= 1'b0;
                rise_ok   <= 1'b0;
                fall_ok   <= 1'b0;
            end else if (track) begin
                prev      <= cur;
                have_prev <= 1'b1;
                if (cur <= lo) rise_ok <= 1'b1;
                if (cur >= hi) fall_ok <= 1'b1;
            end
        end
    end

    assign busy = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST_FILL);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sample_data;
    end

    // Frame index 0 is the oldest kept sample, PRE_TRIG samples before the trigger.
    assign rd_ptr = trig_ptr - PRE_A + rd_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= mem[rd_ptr];
    end
endmodule

// File: tb/tb_trigger_capture.sv
// Randomised bench for trigger_capture: a queue-based capture model predicts trigger index,
// flags and the aligned frame for each armed capture.
module tb_trigger_capture;
    localparam int DATA_W       = 12;
    localparam int CHANNELS     = 2;
    localparam int DEPTH        = 16;
    localparam int PRE_TRIG     = 4;
    localparam int AUTO_TIMEOUT = 8;
    localparam int POST_N       = DEPTH - PRE_TRIG - 1;
    localparam int W            = CHANNELS * DATA_W;
    localparam int MAXV         = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sample_valid = 1'b0;
    logic [W-1:0]      sample_data = '0;
    logic              arm = 1'b0;
    logic              trig_channel = 1'b0;
    logic [DATA_W-1:0] trig_level = '0;
    logic [DATA_W-1:0] trig_hyst = '0;
    logic [1:0]        trig_edge = 2'b00;
    logic              auto_mode = 1'b0;
    logic [3:0]        rd_addr = '0;
    logic [W-1:0]      rd_data;
    logic              busy, triggered, auto_fired, capture_done;

    trigger_capture #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH),
        .PRE_TRIG(PRE_TRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .arm(arm), .trig_channel(trig_channel), .trig_level(trig_level),
        .trig_hyst(trig_hyst), .trig_edge(trig_edge), .auto_mode(auto_mode),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .triggered(triggered),
        .auto_fired(auto_fired), .capture_done(capture_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] s0_q[$];
    logic [DATA_W-1:0] s1_q[$];
    logic [W-1:0]      exp_q[$];
    int                exp_t;
    bit                exp_auto;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sel(input int i);
        return trig_channel ? int'(s1_q[i]) : int'(s0_q[i]);
    endfunction

    // First trigger index over the post-arm valid samples, or -1 if none occurs.
    task automatic find_trigger();
        int lev, hy, lo, hi, p, s;
        bit rise, fall, hit, ok_r, ok_f;
        lev = trig_level;
        hy  = trig_hyst;
        lo  = (lev - hy < 0) ? 0 : lev - hy;
        hi  = (lev + hy > MAXV) ? MAXV : lev + hy;
        exp_t = -1;
        exp_auto = 1'b0;
        for (int i = PRE_TRIG; i < s0_q.size(); i++) begin
            rise = 1'b0;
            fall = 1'b0;
            if (i > 0) begin
                p = sel(i - 1);
                s = sel(i);
                ok_r = (hy == 0);
                ok_f = (hy == 0);
                for (int j = 0; j < i; j++) begin
                    if (sel(j) <= lo) ok_r = 1'b1;
                    if (sel(j) >= hi) ok_f = 1'b1;
                end
                rise = (p < lev) && (s >= lev) && ok_r;
                fall = (p > lev) && (s <= lev) && ok_f;
            end
            case (trig_edge)
                2'b01:   hit = fall;
                2'b10:   hit = rise || fall;
                default: hit = rise;
            endcase
            if (hit) begin
                exp_t = i;
                return;
            end
            if (auto_mode && (i - PRE_TRIG + 1 == AUTO_TIMEOUT)) begin
                exp_t = i;
                exp_auto = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_arm(input string name);
        @(negedge clk);
        arm = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        arm = 1'b0;
        check_eq({name, ":arm_busy"}, busy, 1);
        check_eq({name, ":arm_trig"}, triggered, 0);
        check_eq({name, ":arm_done"}, capture_done, 0);
        check_eq({name, ":arm_auto"}, auto_fired, 0);
    endtask

    task automatic drive_one(input logic [W-1:0] d);
        sample_valid = 1'b1;
        sample_data = d;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    // abort_after >= 0 leaves the capture that many samples after the trigger.
    task automatic run_capture(input string name, input int gap_max, input int abort_after);
        int done_idx;
        bit trig, done;
        find_trigger();
        done_idx = (exp_t < 0) ? -1 : exp_t + POST_N;
        do_arm(name);
        done = 1'b0;
        for (int i = 0; i < s0_q.size(); i++) begin
            if (abort_after >= 0 && exp_t >= 0 && i == exp_t + abort_after) return;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            drive_one({s1_q[i], s0_q[i]});
            trig = (exp_t >= 0) && (i >= exp_t);
            done = (done_idx >= 0) && (i >= done_idx);
            check_eq({name, ":trig"}, triggered, trig);
            check_eq({name, ":auto"}, auto_fired, trig && exp_auto);
            check_eq({name, ":done"}, capture_done, done);
            check_eq({name, ":busy"}, busy, !done);
            @(negedge clk);
            if (done) break;
        end
        if (!done) return;
        // Samples arriving after completion must not disturb the frame.
        for (int k = 0; k < 3; k++) begin
            drive_one(W'($urandom));
            @(negedge clk);
        end
        for (int a = 0; a < DEPTH; a++)
            exp_q.push_back({s1_q[exp_t - PRE_TRIG + a], s0_q[exp_t - PRE_TRIG + a]});
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 4'(a);
            @(posedge clk);
            #1;
            check_eq({name, ":frame"}, rd_data, exp_q.pop_front());
            @(negedge clk);
        end
        check_eq({name, ":done_hold"}, capture_done, 1);
    endtask

    task automatic read_ch0(input int a, output logic [DATA_W-1:0] v);
        @(negedge clk);
        rd_addr = 4'(a);
        @(posedge clk);
        #1;
        v = rd_data[DATA_W-1:0];
    endtask

    task automatic load_ramp();
        s0_q.delete();
        s1_q.delete();
        for (int i = 0; i < 30; i++) begin
            s0_q.push_back(DATA_W'(i * 10));
            s1_q.push_back(DATA_W'(2000 + i * 3));
        end
    endtask

    logic [DATA_W-1:0] v;
    int                w0, w1;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_trig", triggered, 0);
        check_eq("reset_auto", auto_fired, 0);
        check_eq("reset_done", capture_done, 0);
        check_eq("reset_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // Rising ramp, no hysteresis: trigger on the sample equal to 100.
        trig_level = 12'd100; trig_hyst = '0; trig_edge = 2'b00; auto_mode = 1'b0;
        load_ramp();
        run_capture("ramp", 0, -1);
        read_ch0(4, v);  check_eq("ramp_addr4", v, 100);
        read_ch0(0, v);  check_eq("ramp_addr0", v, 60);
        read_ch0(15, v); check_eq("ramp_addr15", v, 210);

        // Falling with hysteresis: 80 arms the falling flag, first 45 triggers.
        trig_level = 12'd50; trig_hyst = 12'd20; trig_edge = 2'b01;
        s0_q = '{60, 60, 60, 60, 80, 60, 45, 70, 65, 45};
        s1_q.delete();
        for (int i = 0; i < 10; i++) s1_q.push_back(DATA_W'($urandom));
        while (s0_q.size() < 20) begin
            s0_q.push_back(DATA_W'($urandom));
            s1_q.push_back(DATA_W'($urandom));
        end
        run_capture("fall", 0, -1);
        read_ch0(4, v); check_eq("fall_addr4", v, 45);

        // Nothing reaches level+hyst, so no falling trigger is ever accepted.
        s0_q.delete();
        s1_q.delete();
        for (int i = 0; i < 40; i++) begin
            s0_q.push_back(DATA_W'($urandom_range(0, 69)));
            s1_q.push_back(DATA_W'($urandom));
        end
        run_capture("nofall", 0, -1);

        // Auto mode on a flat input well below the level.
        trig_level = 12'd100; trig_hyst = '0; trig_edge = 2'b00; auto_mode = 1'b1;
        s0_q.delete();
        s1_q.delete();
        for (int i = 0; i < 30; i++) begin
            s0_q.push_back(12'd30);
            s1_q.push_back(DATA_W'($urandom));
        end
        run_capture("auto", 0, -1);
        read_ch0(0, v);  check_eq("auto_addr0", v, 30);
        read_ch0(15, v); check_eq("auto_addr15", v, 30);

        // Re-arm in the middle of the post-trigger fill, then a fresh capture.
        auto_mode = 1'b0;
        load_ramp();
        run_capture("abort", 0, 5);
        for (int i = 0; i < 30; i++) s1_q[i] = DATA_W'($urandom);
        run_capture("rearm", 0, -1);

        // Gapped sample_valid must give the same frame.
        load_ramp();
        run_capture("gaps", 1, -1);

        // Asynchronous reset while waiting for a trigger.
        s0_q.delete();
        s1_q.delete();
        for (int i = 0; i < 6; i++) begin
            s0_q.push_back(12'd30);
            s1_q.push_back(12'd30);
        end
        run_capture("prerst", 0, -1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_trig", triggered, 0);
        check_eq("arst_done", capture_done, 0);
        check_eq("arst_auto", auto_fired, 0);
        check_eq("arst_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_one(W'($urandom));
            check_eq("idle_busy", busy, 0);
            check_eq("idle_trig", triggered, 0);
        end

        // Random walks with random trigger settings.
        for (int r = 0; r < 10; r++) begin
            trig_channel = 1'($urandom_range(0, 1));
            trig_level   = DATA_W'($urandom_range(300, 3800));
            trig_hyst    = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom_range(1, 300));
            trig_edge    = 2'($urandom_range(0, 3));
            auto_mode    = 1'($urandom_range(0, 1));
            w0 = $urandom_range(0, MAXV);
            w1 = $urandom_range(0, MAXV);
            s0_q.delete();
            s1_q.delete();
            for (int i = 0; i < 80; i++) begin
                w0 = w0 + $urandom_range(0, 600) - 300;
                w1 = w1 + $urandom_range(0, 600) - 300;
                w0 = (w0 < 0) ? 0 : (w0 > MAXV) ? MAXV : w0;
                w1 = (w1 < 0) ? 0 : (w1 > MAXV) ? MAXV : w1;
                s0_q.push_back(DATA_W'(w0));
                s1_q.push_back(DATA_W'(w1));
            end
            run_capture("rand", 2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
